// File: rtl/serial_rca_adder_pkg.sv
// Shared definitions for the digit-serial ripple-carry adder: FSM encoding and
// counter sizing.
package serial_rca_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Digit counter width; a single-digit build still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/serial_rca_adder_digit_adder.sv
// Combinational W-bit ripple adder for one digit, plus its full-adder cell.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module digit_adder #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);
  logic [W:0] c;

  assign c[0] = ci;
  assign co   = c[W];

  for (genvar i = 0; i < W; i++) begin : g_fa
    fa_cell u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end
endmodule

// File: rtl/serial_rca_adder.sv
// Digit-serial add/subtract: DIGIT bits per clock with a registered carry,
// operands and result exchanged over valid/ready handshakes.
module serial_rca_adder
  import serial_rca_adder_pkg::*;
#(
  parameter int unsigned A_WIDTH = 16,
  parameter int unsigned B_WIDTH = 20,
  parameter int unsigned DIGIT   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic               cin,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [B_WIDTH-1:0] s,
  output logic               cout
);

  localparam int unsigned NDIG = B_WIDTH / DIGIT;
  localparam int unsigned CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t state, state_nxt;

  logic [B_WIDTH-1:0] op_a;
  logic [B_WIDTH-1:0] op_b;
  logic               carry;
  logic [CW-1:0]      cnt;

  logic [31:0]        shamt;
  logic [B_WIDTH-1:0] a_sh;
  logic [B_WIDTH-1:0] b_sh;
  logic [B_WIDTH-1:0] dmask;
  logic [B_WIDTH-1:0] s_nxt;
  logic [DIGIT-1:0]   dx;
  logic [DIGIT-1:0]   dy;
  logic [DIGIT-1:0]   dsum;
  logic               dco;
  logic               last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
      ST_RUN:  if (last)      state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Select the current digit of each operand and merge the new sum digit into s
  always_comb begin
    shamt = 32'(cnt) * DIGIT;
    a_sh  = op_a >> shamt;
    b_sh  = op_b >> shamt;
    dx    = a_sh[DIGIT-1:0];
    dy    = b_sh[DIGIT-1:0];
    dmask = B_WIDTH'({DIGIT{1'b1}}) << shamt;
    s_nxt = (s & ~dmask) | (B_WIDTH'(dsum) << shamt);
    last  = (cnt == LAST);
  end

  digit_adder #(.W(DIGIT)) u_digit (
    .x   (dx),
    .y   (dy),
    .ci  (carry),
    .sum (dsum),
    .co  (dco)
  );

  // Operand, result, counter and handshake registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
    end else begin
      in_ready  <= (state_nxt == ST_IDLE);
      out_valid <= (state_nxt == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            // Subtraction is b + ~zext(a) + ~cin; upper bits of ~zext(a) are 1s
            op_a  <= sub ? ~B_WIDTH'(a) : B_WIDTH'(a);
            op_b  <= b;
            carry <= cin ^ sub;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          s     <= s_nxt;
          carry <= dco;
          if (last) begin
            cout <= dco;
            cnt  <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rca_adder.sv
// Scoreboard bench for serial_rca_adder: a main DIGIT=4 instance under directed
// and random traffic, plus DIGIT=2 and DIGIT=20 instances running back-to-back.
module tb_serial_rca_adder;

  localparam int unsigned AW = 16;
  localparam int unsigned BW = 20;

  typedef struct {
    logic [BW-1:0] s;
    logic          c;
    int            t;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          aux_en = 1'b1;
  logic [AW-1:0] a = '0;
  logic [BW-1:0] b = '0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;

  logic [2:0]    ir;
  logic [2:0]    ov;
  logic [2:0]    co;
  logic [BW-1:0] s0, s1, s2;

  int n_pass = 0;
  int n_total = 0;

  exp_t sb [3][$];
  int   cyc = 0;
  int   last_acc [3];
  bit   have_last [3];
  bit   prev_ov [3];
  int   n_xfer [3];
  bit   b2b = 1'b0;
  int   b2b_n = 0;

  always #5 clk = ~clk;

  serial_rca_adder #(.A_WIDTH(AW), .B_WIDTH(BW), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov[0]), .out_ready(out_ready), .s(s0), .cout(co[0])
  );

  serial_rca_adder #(.A_WIDTH(AW), .B_WIDTH(BW), .DIGIT(2)) dut_d2 (
    .clk(clk), .rst(rst), .in_valid(aux_en), .in_ready(ir[1]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov[1]), .out_ready(aux_en), .s(s1), .cout(co[1])
  );

  serial_rca_adder #(.A_WIDTH(AW), .B_WIDTH(BW), .DIGIT(20)) dut_d20 (
    .clk(clk), .rst(rst), .in_valid(aux_en), .in_ready(ir[2]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov[2]), .out_ready(aux_en), .s(s2), .cout(co[2])
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  // Reference: plain integer arithmetic; bit 20 is the carry, or "no borrow" when subtracting
  function automatic logic [BW:0] model(input logic [AW-1:0] ai, input logic [BW-1:0] bi,
                                        input logic ci, input logic sbi);
    logic [BW:0] r;
    if (sbi) begin
      r = {1'b0, bi} - (BW+1)'(ai) - (BW+1)'(ci);
      r[BW] = ~r[BW];
    end else begin
      r = (BW+1)'(bi) + (BW+1)'(ai) + (BW+1)'(ci);
    end
    return r;
  endfunction

  function automatic int ndig_of(input int d);
    return (d == 0) ? 5 : (d == 1) ? 10 : 1;
  endfunction

  // Monitor: push on accept, pop and compare on transfer, timing checks
  always @(negedge clk) begin
    logic          iv, rdy, cv;
    logic [BW-1:0] sv;
    logic [BW:0]   r;
    exp_t          e;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      iv  = (d == 0) ? in_valid : aux_en;
      rdy = (d == 0) ? out_ready : aux_en;
      sv  = (d == 0) ? s0 : (d == 1) ? s1 : s2;
      cv  = co[d];
      if (rst) begin
        sb[d].delete();
        have_last[d] = 1'b0;
        prev_ov[d] = 1'b0;
      end else begin
        // Accept sampled one negedge before edge E; valid seen NDIG+1 negedges later
        if (ov[d] && !prev_ov[d] && sb[d].size() > 0)
          chk($sformatf("dut%0d latency", d), 32'(cyc - sb[d][0].t), 32'(ndig_of(d) + 1));
        if (ov[d] && rdy) begin
          chk($sformatf("dut%0d result expected", d), 32'(sb[d].size() > 0), 32'd1);
          if (sb[d].size() > 0) begin
            e = sb[d].pop_front();
            chk($sformatf("dut%0d s", d), 32'(sv), 32'(e.s));
            chk($sformatf("dut%0d cout", d), 32'(cv), 32'(e.c));
            n_xfer[d]++;
          end
        end
        if (ir[d] && iv) begin
          r = model(a, b, cin, sub);
          sb[d].push_back('{s: r[BW-1:0], c: r[BW], t: cyc});
          if (d == 0) begin
            if (b2b) begin
              if (b2b_n > 0)
                chk("dut0 b2b spacing", 32'(cyc - last_acc[0]), 32'(ndig_of(0) + 2));
              b2b_n++;
            end
          end else if (have_last[d]) begin
            chk($sformatf("dut%0d spacing", d), 32'(cyc - last_acc[d]), 32'(ndig_of(d) + 2));
          end
          last_acc[d] = cyc;
          have_last[d] = 1'b1;
        end
        prev_ov[d] = ov[d];
      end
    end
  end

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (ir[0] && in_valid) ok = 1'b1;
    end
    if (!ok) chk("accept timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic [AW-1:0] ai, input logic [BW-1:0] bi,
                     input logic ci, input logic sbi);
    a = ai; b = bi; cin = ci; sub = sbi;
    in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (ir[0]) ok = 1'b1;
    end
    if (!ok) chk("idle timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [BW:0] r;
    int          x0;
    bit          ok;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 32'(ir[0]), 32'd1);
    chk("reset out_valid", 32'(ov[0]), 32'd0);
    chk("reset s", 32'(s0), 32'd0);
    chk("reset cout", 32'(co[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed arithmetic cases
    txn(16'hFFFF, 20'h00001, 1'b1, 1'b0); wait_idle();
    txn(16'h0001, 20'hFFFFF, 1'b0, 1'b0); wait_idle();
    txn(16'h0011, 20'h00010, 1'b0, 1'b1); wait_idle();
    txn(16'h0001, 20'h00010, 1'b1, 1'b1); wait_idle();

    // Backpressure in DONE while inputs wiggle
    out_ready = 1'b0;
    r = model(16'hABCD, 20'h12345, 1'b1, 1'b0);
    txn(16'hABCD, 20'h12345, 1'b1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (ov[0]) ok = 1'b1;
    end
    if (!ok) chk("bp valid timeout", 32'd0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      a = AW'($urandom); b = BW'($urandom); in_valid = ~in_valid;
      @(negedge clk);
      chk("bp s hold", 32'(s0), 32'(r[BW-1:0]));
      chk("bp cout hold", 32'(co[0]), 32'(r[BW]));
      chk("bp in_ready low", 32'(ir[0]), 32'd0);
      chk("bp out_valid held", 32'(ov[0]), 32'd1);
    end
    x0 = n_xfer[0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp one transfer", 32'(n_xfer[0] - x0), 32'd1);
    chk("bp out_valid drop", 32'(ov[0]), 32'd0);
    wait_idle();

    // Reset during the second RUN cycle
    txn(16'h5555, 20'h0AAAA, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrun out_valid", 32'(ov[0]), 32'd0);
    chk("midrun s", 32'(s0), 32'd0);
    chk("midrun cout", 32'(co[0]), 32'd0);
    chk("midrun in_ready", 32'(ir[0]), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    txn(16'h1234, 20'h01000, 1'b0, 1'b0); wait_idle();

    // Back-to-back with in_valid held high
    b2b = 1'b1;
    a = AW'($urandom); b = BW'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_accept();
      a = AW'($urandom); b = BW'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    end
    in_valid = 1'b0;
    b2b = 1'b0;
    wait_idle();

    // Random operands with random consumer stalls
    for (int k = 0; k < 16; k++) begin
      txn(AW'($urandom), BW'($urandom), 1'($urandom), 1'($urandom));
      ok = 1'b0;
      for (int i = 0; i < 80 && !ok; i++) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom);
        if (ir[0]) ok = 1'b1;
      end
      if (!ok) chk("random drain timeout", 32'd0, 32'd1);
      out_ready = 1'b1;
    end

    repeat (10) @(posedge clk);
    #1;
    chk("dut0 scoreboard empty", 32'(sb[0].size()), 32'd0);
    chk("dut1 produced results", 32'(n_xfer[1] > 10), 32'd1);
    chk("dut2 produced results", 32'(n_xfer[2] > 10), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
